// File: rtl/tristate_bus_arbiter_pkg.sv
// tsbus_pkg: shared definitions for the tri-state bus arbiter.
//   ENC_*   : state encodings used by the arbiter FSM
//   state_t : FSM state type built on those encodings
package tsbus_pkg;

   localparam logic [1:0] ENC_IDLE  = 2'd0;
   localparam logic [1:0] ENC_TURN  = 2'd1;
   localparam logic [1:0] ENC_DRIVE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ENC_IDLE,
      TURN  = ENC_TURN,
      DRIVE = ENC_DRIVE
   } state_t;

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// tristate_bus_arbiter_if: request/grant bundle between the requesters and
// the arbiter that controls the bufif1 enables of one shared net.
//   req     : per-requester level request
//   oe      : per-requester bufif1 enable (at most one high)
//   gnt_id  : current or most recent owner
//   busy    : some oe bit is high
//   timeout : one-cycle pulse on forced release
// Modports: master = arbiter side, slave = requester side.
interface tristate_bus_arbiter_if #(
   parameter int NREQ = 4
) ();
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] oe;
   logic [IDW-1:0]  gnt_id;
   logic            busy;
   logic            timeout;

   modport master (input req, output oe, output gnt_id, output busy, output timeout);
   modport slave  (output req, input oe, input gnt_id, input busy, input timeout);
endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector
//   last   : index of the previous owner (search starts at last+1)
//   winner : first requesting index at or after last+1, wrapping
//   valid  : any request present
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [IDW-1:0]  winner,
   output logic            valid
);

   logic [IDW-1:0] idx;

   // Walk from the farthest candidate back to the nearest so the nearest
   // requester after 'last' is the final assignment and therefore wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = IDW'((int'(last) + i) % NREQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: grants one requester at a time the enable of a
// shared bufif1-driven net. Round-robin arbitration, an all-off turnaround
// of TURN_CYC cycles before each grant, and a forced release after MAX_HOLD
// driven cycles. All outputs are registered.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : master side of tristate_bus_arbiter_if (req in; oe/gnt_id/busy/timeout out)
module tristate_bus_arbiter
   import tsbus_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 16,
   parameter int TURN_CYC = 1
) (
   input  logic clk,
   input  logic rst,
   tristate_bus_arbiter_if.master bus
);

   localparam int IDW = $clog2(NREQ);
   // One counter serves both the turnaround countdown and the hold count.
   localparam int CMAX = (MAX_HOLD > TURN_CYC) ? MAX_HOLD : TURN_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   state_t          state, state_n;
   logic [IDW-1:0]  win, win_n;     // latched candidate / owner
   logic [IDW-1:0]  ptr, ptr_n;     // round-robin pointer (last granted)
   logic [IDW-1:0]  gnt, gnt_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [NREQ-1:0] oe, oe_n;
   logic            busy_q, busy_n;
   logic            to_q, to_n;
   logic [IDW-1:0]  pick_id;
   logic            pick_vld;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (bus.req),
      .last   (ptr),
      .winner (pick_id),
      .valid  (pick_vld)
   );

   always_comb begin
      state_n = state;
      win_n   = win;
      ptr_n   = ptr;
      gnt_n   = gnt;
      cnt_n   = cnt;
      oe_n    = '0;
      busy_n  = 1'b0;
      to_n    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               win_n   = pick_id;
               cnt_n   = CW'(TURN_CYC - 1);
               state_n = TURN;
            end
         end
         TURN: begin
            if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else if (bus.req[win]) begin
               // Pointer moves only when a grant is actually issued.
               state_n   = DRIVE;
               ptr_n     = win;
               gnt_n     = win;
               cnt_n     = CW'(1);
               oe_n[win] = 1'b1;
               busy_n    = 1'b1;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         DRIVE: begin
            // Release is checked first so a drop on the final hold cycle
            // is a normal release rather than a timeout.
            if (!bus.req[win]) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CW'(MAX_HOLD)) begin
               state_n = IDLE;
               cnt_n   = '0;
               to_n    = 1'b1;
            end else begin
               cnt_n     = cnt + CW'(1);
               oe_n[win] = 1'b1;
               busy_n    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         win    <= '0;
         ptr    <= IDW'(NREQ - 1);
         gnt    <= '0;
         cnt    <= '0;
         oe     <= '0;
         busy_q <= 1'b0;
         to_q   <= 1'b0;
      end else begin
         state  <= state_n;
         win    <= win_n;
         ptr    <= ptr_n;
         gnt    <= gnt_n;
         cnt    <= cnt_n;
         oe     <= oe_n;
         busy_q <= busy_n;
         to_q   <= to_n;
      end
   end

   assign bus.oe      = oe;
   assign bus.gnt_id  = gnt;
   assign bus.busy    = busy_q;
   assign bus.timeout = to_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed scenarios plus a long randomized run
// against a cycle-level reference model; NREQ bufif1 drivers share one net.
module tb_tristate_bus_arbiter;

   localparam int NREQ     = 4;
   localparam int MAX_HOLD = 16;
   localparam int TURN_CYC = 1;
   localparam int IDW      = $clog2(NREQ);
   localparam int PER      = MAX_HOLD + TURN_CYC + 1;
   localparam int BOUND    = NREQ * (MAX_HOLD + TURN_CYC + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tristate_bus_arbiter_if #(.NREQ(NREQ)) ifc ();

   tristate_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   // Shared tri-state net
   logic [NREQ-1:0] dat = '0;
   wire             bus_net;
   for (genvar g = 0; g < NREQ; g++) begin : g_drv
      bufif1 u_buf (bus_net, dat[g], ifc.oe[g]);
   end

   // Contention / pull monitor
   int net_x = 0;
   always @(negedge clk) begin
      if ($countones(ifc.oe) > 1 || (ifc.oe != '0 && $isunknown(bus_net)))
         net_x++;
   end

   // Reference model: owner / candidate bookkeeping in plain integers
   int              m_own = -1, m_cand = -1, m_wait = 0, m_held = 0;
   int              m_last = NREQ - 1, m_gnt = 0;
   logic [NREQ-1:0] m_oe = '0;
   logic            m_busy = 1'b0, m_to = 1'b0;

   task automatic model_edge();
      if (rst) begin
         m_own = -1; m_cand = -1; m_wait = 0; m_held = 0;
         m_last = NREQ - 1; m_gnt = 0;
         m_oe = '0; m_busy = 1'b0; m_to = 1'b0;
         return;
      end
      m_to = 1'b0;
      if (m_own >= 0) begin
         if (!ifc.req[m_own]) m_own = -1;
         else if (m_held == MAX_HOLD) begin m_own = -1; m_to = 1'b1; end
         else m_held++;
      end else if (m_cand >= 0) begin
         if (m_wait > 1) m_wait--;
         else begin
            if (ifc.req[m_cand]) begin
               m_own = m_cand; m_last = m_cand; m_gnt = m_cand; m_held = 1;
            end
            m_cand = -1;
         end
      end else if (ifc.req != '0) begin
         for (int k = 1; k <= NREQ; k++)
            if (m_cand < 0 && ifc.req[(m_last + k) % NREQ]) m_cand = (m_last + k) % NREQ;
         m_wait = TURN_CYC;
      end
      m_oe   = (m_own >= 0) ? (NREQ'(1) << m_own) : '0;
      m_busy = (m_own >= 0);
   endtask

   // One clock: model follows the edge, returns at the following negedge
   task automatic cyc();
      @(posedge clk);
      model_edge();
      dat = NREQ'($urandom);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ifc.req = '0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      ifc.req = NREQ'($urandom);
      cyc();
      cyc();
      checks++;
      if (ifc.oe !== '0 || ifc.busy !== 1'b0 || ifc.timeout !== 1'b0 || ifc.gnt_id !== '0) begin
         errors++;
         $display("FAIL reset oe=%b busy=%b to=%b gnt=%0d, want 0/0/0/0",
                  ifc.oe, ifc.busy, ifc.timeout, ifc.gnt_id);
      end
      rst = 1'b0;
      ifc.req = '0;
   endtask

   task automatic test_single();
      logic [NREQ-1:0] eo;
      do_reset();
      ifc.req = 4'b0001;
      for (int c = 1; c <= 7; c++) begin
         cyc();
         eo = (c >= 1 + TURN_CYC && c <= 6) ? 4'b0001 : 4'b0000;
         checks++;
         if (ifc.oe !== eo || ifc.busy !== (eo != '0)) begin
            errors++;
            $display("FAIL single c=%0d oe=%b busy=%b, want %b", c, ifc.oe, ifc.busy, eo);
         end
         if (c == 6) ifc.req = '0;
      end
   endtask

   task automatic test_rotate();
      logic [NREQ-1:0] eo;
      int eg, k, p, first, nbad;
      logic et;
      first = 1 + TURN_CYC;
      nbad  = 0;
      do_reset();
      ifc.req = '1;
      for (int c = 1; c < first + 5 * PER; c++) begin
         cyc();
         if (c < first) begin
            eo = '0; eg = 0; et = 1'b0;
         end else begin
            k  = (c - first) / PER;
            p  = (c - first) % PER;
            eg = k % NREQ;
            eo = (p < MAX_HOLD) ? (NREQ'(1) << eg) : '0;
            et = (p == MAX_HOLD);
         end
         checks++;
         if (ifc.oe !== eo || ifc.gnt_id !== IDW'(eg) || ifc.timeout !== et) begin
            errors++;
            $display("FAIL rotate c=%0d oe=%b gnt=%0d to=%b, want %b/%0d/%b",
                     c, ifc.oe, ifc.gnt_id, ifc.timeout, eo, eg, et);
         end
         if ($countones(ifc.oe) == 1) begin
            if (ifc.oe[0] && bus_net !== dat[0]) nbad++;
            if (ifc.oe[1] && bus_net !== dat[1]) nbad++;
            if (ifc.oe[2] && bus_net !== dat[2]) nbad++;
            if (ifc.oe[3] && bus_net !== dat[3]) nbad++;
         end
      end
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL rotate_net wrong net value in %0d cycles, want 0", nbad);
      end
   endtask

   task automatic test_skip();
      int bad;
      do_reset();
      ifc.req = 4'b0101;
      for (int c = 1; c <= 4; c++) cyc();
      ifc.req = 4'b0100;
      for (int c = 5; c <= 7; c++) cyc();
      checks++;
      if (ifc.oe !== 4'b0100 || ifc.gnt_id !== IDW'(2)) begin
         errors++;
         $display("FAIL skip oe=%b gnt=%0d, want 0100/2", ifc.oe, ifc.gnt_id);
      end
      ifc.req = 4'b0101;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         cyc();
         if ((ifc.oe & 4'b1010) != '0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL skip_idle granted idle requester in %0d cycles, want 0", bad);
      end
      ifc.req = '0;
   endtask

   task automatic test_abort();
      int seen;
      do_reset();
      ifc.req = 4'b0010;
      cyc();
      ifc.req = '0;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         cyc();
         if (ifc.oe != '0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort oe high in %0d cycles, want 0", seen);
      end
      // Pointer must still be NREQ-1: search 0,1 -> grant 1 (not 3)
      ifc.req = 4'b1010;
      for (int c = 0; c < 1 + TURN_CYC; c++) cyc();
      checks++;
      if (ifc.oe !== 4'b0010 || ifc.gnt_id !== IDW'(1)) begin
         errors++;
         $display("FAIL abort_ptr oe=%b gnt=%0d, want 0010/1", ifc.oe, ifc.gnt_id);
      end
      ifc.req = '0;
   endtask

   task automatic test_simul();
      do_reset();
      ifc.req = 4'b0001;
      for (int c = 1; c <= TURN_CYC + MAX_HOLD; c++) cyc();
      checks++;
      if (ifc.oe !== 4'b0001) begin
         errors++;
         $display("FAIL simul_hold oe=%b, want 0001", ifc.oe);
      end
      ifc.req = '0;
      cyc();
      checks++;
      if (ifc.oe !== '0 || ifc.timeout !== 1'b0) begin
         errors++;
         $display("FAIL simul_release oe=%b to=%b, want 0000/0", ifc.oe, ifc.timeout);
      end
   endtask

   task automatic test_rst_drive();
      do_reset();
      ifc.req = 4'b0100;
      for (int c = 1; c <= 1 + TURN_CYC; c++) cyc();
      checks++;
      if (ifc.oe !== 4'b0100 || ifc.gnt_id !== IDW'(2)) begin
         errors++;
         $display("FAIL rst_drive_pre oe=%b gnt=%0d, want 0100/2", ifc.oe, ifc.gnt_id);
      end
      cyc();
      rst = 1'b1;
      cyc();
      checks++;
      if (ifc.oe !== '0 || ifc.gnt_id !== '0 || ifc.timeout !== 1'b0 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_drive oe=%b gnt=%0d to=%b busy=%b, want 0000/0/0/0",
                  ifc.oe, ifc.gnt_id, ifc.timeout, ifc.busy);
      end
      rst = 1'b0;
      ifc.req = '0;
   endtask

   task automatic test_random();
      int wait_c[NREQ];
      int lat_bad, mis;
      lat_bad = 0;
      mis = 0;
      for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(15) == 0) ifc.req[i] = ~ifc.req[i];
         cyc();
         checks++;
         if (ifc.oe !== m_oe || ifc.busy !== m_busy || ifc.timeout !== m_to ||
             ifc.gnt_id !== IDW'(m_gnt)) begin
            errors++;
            mis++;
            if (mis <= 10)
               $display("FAIL random n=%0d oe=%b busy=%b to=%b gnt=%0d, want %b/%b/%b/%0d",
                        n, ifc.oe, ifc.busy, ifc.timeout, ifc.gnt_id, m_oe, m_busy, m_to, m_gnt);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (ifc.req[i] && !ifc.oe[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > BOUND) lat_bad++;
         end
      end
      checks++;
      if (lat_bad !== 0) begin
         errors++;
         $display("FAIL random_latency %0d cycles over bound %0d, want 0", lat_bad, BOUND);
      end
      checks++;
      if (net_x !== 0) begin
         errors++;
         $display("FAIL net_contention %0d cycles with multiple/x drivers, want 0", net_x);
      end
      ifc.req = '0;
   endtask

   initial begin
      ifc.req = '0;
      test_reset();
      test_single();
      test_rotate();
      test_skip();
      test_abort();
      test_simul();
      test_rst_drive();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
